parity_stream_accumulator: RTL

//  Streaming parity generator. Successor to the fixed 4-input XOR parity cell.

---
 rtl/parity_stream_accumulator_pkg.sv | 17 +
 rtl/parity_stream_accumulator_word_parity.sv | 19 +
 rtl/parity_stream_accumulator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/parity_stream_accumulator_pkg.sv
// Shared types and helpers for the streaming parity accumulator and its
// future companion checker.
package parity_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } par_state_t;

   localparam int XOR_MAX_W = 64;

   // Checker-side parity reference; narrower words are zero-extended by the caller.
   function automatic logic xor_reduce(input logic [XOR_MAX_W-1:0] value);
      return ^value;
   endfunction

endpackage

// File: rtl/parity_stream_accumulator_word_parity.sv
// Generalised parity cell: folds every bit of a WIDTH-bit word into one bit.
module word_parity
   import parity_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] data_i,
   output logic             parity_o
);

   // Linear fold is written for clarity; synthesis balances it into a tree.
   always_comb begin
      parity_o = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         parity_o = parity_o ^ data_i[i];
      end
   end

endmodule

// File: rtl/parity_stream_accumulator.sv
// Streaming packet parity generator: accumulates word parity across a packet
// and presents one parity/count/overflow result per packet on a handshake.
module parity_stream_accumulator
   import parity_pkg::*;
#(
   parameter  int WIDTH     = 4,
   parameter  int MAX_WORDS = 16,
   localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             odd_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_parity,
   output logic [CNT_W-1:0] out_count,
   output logic             out_err
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_WORDS);

   par_state_t       state_q, state_d;
   logic             acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic             err_q, err_d;
   logic             outValid_q, outValid_d;
   logic             outParity_q, outParity_d;
   logic [CNT_W-1:0] outCount_q, outCount_d;
   logic             outErr_q, outErr_d;

   logic             wordPar;
   logic             beatFire;
   logic             overflow;
   logic             beatMode;
   logic [CNT_W-1:0] cntInc;

   word_parity #(.WIDTH(WIDTH)) u_word_parity (
      .data_i   (in_data),
      .parity_o (wordPar)
   );

   // Acceptance depends only on registered state, never on out_ready.
   assign in_ready = (state_q == ACCUM);

   assign beatFire = in_valid && in_ready;
   assign overflow = (cnt_q == CntMax);
   assign cntInc   = overflow ? cnt_q : cnt_q + CNT_W'(1);
   assign beatMode = (cnt_q == '0) ? odd_mode : mode_q;

   // Next-state: accumulate beats in ACCUM, park the result in HOLD until taken.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      err_d       = err_q;
      outValid_d  = outValid_q;
      outParity_d = outParity_q;
      outCount_d  = outCount_q;
      outErr_d    = outErr_q;

      case (state_q)
         ACCUM: begin
            if (beatFire) begin
               acc_d = acc_q ^ wordPar;
               cnt_d = cntInc;
               if (overflow) begin
                  err_d = 1'b1;
               end
               if (cnt_q == '0) begin
                  mode_d = odd_mode;
               end
               if (in_last) begin
                  outParity_d = acc_q ^ wordPar ^ beatMode;
                  outCount_d  = cntInc;
                  outErr_d    = err_q | overflow;
                  outValid_d  = 1'b1;
                  acc_d       = 1'b0;
                  cnt_d       = '0;
                  err_d       = 1'b0;
                  state_d     = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               outValid_d = 1'b0;
               state_d    = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // Reset discards any partial packet and any pending result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ACCUM;
         acc_q       <= 1'b0;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         err_q       <= 1'b0;
         outValid_q  <= 1'b0;
         outParity_q <= 1'b0;
         outCount_q  <= '0;
         outErr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         err_q       <= err_d;
         outValid_q  <= outValid_d;
         outParity_q <= outParity_d;
         outCount_q  <= outCount_d;
         outErr_q    <= outErr_d;
      end
   end

   assign out_valid  = outValid_q;
   assign out_parity = outParity_q;
   assign out_count  = outCount_q;
   assign out_err    = outErr_q;

endmodule
